display_scan_ctl: RTL and testbench

//  Scan sequencer for the control-panel 8-digit multiplexed 7-seg display.

---
 rtl/display_scan_ctl_if.sv | 9 +
 rtl/display_scan_ctl.sv | 99 +++++++++
 tb/tb_display_scan_ctl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctl_if.sv
// rtl/display_scan_ctl_if.sv - image update handshake between a display producer and the scan sequencer
interface display_scan_ctl_if;
    logic        upd_req;
    logic [63:0] upd_img;
    logic        upd_ack;

    modport master (output upd_req, output upd_img, input upd_ack);
    modport slave  (input upd_req, input upd_img, output upd_ack);
endinterface

// File: rtl/display_scan_ctl.sv
// rtl/display_scan_ctl.sv - 8-digit 7-seg scan sequencer with blanking, PWM brightness and frame-aligned double buffer
module display_scan_ctl #(
    parameter int DIV     = 1000,
    parameter int DEAD    = 2,
    parameter bit SEG_INV = 1'b0,
    parameter bit DIG_INV = 1'b0
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    display_scan_ctl_if.slave       upd,
    input  logic [3:0]              brightness,
    input  logic                    blank,
    output logic [7:0]              seg,
    output logic [7:0]              dig,
    output logic [2:0]              digit_idx,
    output logic                    frame_start
);
    localparam int          PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [4:0]  DEAD5   = 5'(DEAD);
    localparam logic [7:0]  SEG_OFF = SEG_INV ? 8'hFF : 8'h00;
    localparam logic [7:0]  DIG_OFF = DIG_INV ? 8'hFF : 8'h00;

    logic [PW-1:0] presc_q,   presc_d;
    logic [3:0]    p_q,       p_d;
    logic [2:0]    digit_q,   digit_d;
    logic [3:0]    bright_q,  bright_d;
    logic [63:0]   active_q,  active_d;
    logic [63:0]   shadow_q,  shadow_d;
    logic          pending_q, pending_d;
    logic          ack_q,     ack_d;
    logic          fs_q,      fs_d;
    logic [7:0]    seg_q,     seg_d;
    logic [7:0]    dig_q,     dig_d;
    logic [2:0]    idx_q,     idx_d;

    logic tick, slot_end, frame_end, accept, swap, lit;

    always_comb begin
        tick      = (presc_q == PW'(DIV - 1));
        slot_end  = tick && (p_q == 4'hF);
        frame_end = slot_end && (digit_q == 3'd7);

        presc_d   = tick ? '0 : presc_q + PW'(1);
        p_d       = tick ? p_q + 4'd1 : p_q;
        digit_d   = slot_end ? digit_q + 3'd1 : digit_q;
        bright_d  = slot_end ? brightness : bright_q;

        // A swap only happens with pending set, so it can never coincide with an accept.
        accept    = upd.upd_req && !pending_q;
        swap      = frame_end && pending_q;
        shadow_d  = accept ? upd.upd_img : shadow_q;
        active_d  = swap ? shadow_q : active_q;
        pending_d = accept ? 1'b1 : (swap ? 1'b0 : pending_q);
        ack_d     = accept;
        fs_d      = frame_end;

        // 5-bit compare lets DEAD + brightness run past the slot end without wrapping.
        lit       = ({1'b0, p_q} >= DEAD5) && ({1'b0, p_q} < DEAD5 + {1'b0, bright_q}) && !blank;
        seg_d     = (lit ? active_q[{digit_q, 3'b000} +: 8] : 8'h00) ^ SEG_OFF;
        dig_d     = (lit ? (8'h01 << digit_q) : 8'h00) ^ DIG_OFF;
        idx_d     = digit_q;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            p_q       <= 4'd0;
            digit_q   <= 3'd0;
            bright_q  <= 4'd0;
            active_q  <= 64'd0;
            shadow_q  <= 64'd0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
            idx_q     <= 3'd0;
        end else begin
            presc_q   <= presc_d;
            p_q       <= p_d;
            digit_q   <= digit_d;
            bright_q  <= bright_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            fs_q      <= fs_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            idx_q     <= idx_d;
        end
    end

    assign upd.upd_ack = ack_q;
    assign frame_start = fs_q;
    assign seg         = seg_q;
    assign dig         = dig_q;
    assign digit_idx   = idx_q;
endmodule

// File: tb/tb_display_scan_ctl.sv
// tb/tb_display_scan_ctl.sv - directed bench for display_scan_ctl, plain and inverted-pin instances
module tb_display_scan_ctl;
    localparam int DIV  = 4;
    localparam int DEAD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] brightness;
    logic       blank;
    logic [7:0] seg, dig, seg_n, dig_n;
    logic [2:0] didx, didx_n;
    logic       fs, fs_n;

    always #5 clk = ~clk;

    display_scan_ctl_if ifc ();
    display_scan_ctl_if ifc_n ();

    display_scan_ctl #(.DIV(DIV), .DEAD(DEAD), .SEG_INV(1'b0), .DIG_INV(1'b0)) dut (
        .clk_sys(clk), .rst(rst), .upd(ifc), .brightness(brightness), .blank(blank),
        .seg(seg), .dig(dig), .digit_idx(didx), .frame_start(fs)
    );

    display_scan_ctl #(.DIV(DIV), .DEAD(DEAD), .SEG_INV(1'b1), .DIG_INV(1'b1)) dut_n (
        .clk_sys(clk), .rst(rst), .upd(ifc_n), .brightness(brightness), .blank(blank),
        .seg(seg_n), .dig(dig_n), .digit_idx(didx_n), .frame_start(fs_n)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int ack_cyc = -1;
    int ack_count = 0;
    int req_cyc = 0;
    int fs_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (ifc.upd_ack === 1'b1) begin
            ack_cyc = cyc;
            ack_count++;
            ifc.upd_req = 1'b0;
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (fs !== 1'b1 && n < 600);
        chk("fs_found", fs, 1);
    endtask

    task automatic drive_req(input logic [63:0] img);
        ifc.upd_img = img;
        ifc.upd_req = 1'b1;
        req_cyc     = cyc;
    endtask

    // Starts at a frame_start sample; sample k shows counter position k of the next frame.
    task automatic scan(input logic [63:0] img, input int br, input int exp_cnt,
                        input int rq1_k, input logic [63:0] rq1_img,
                        input int rq2_k, input logic [63:0] rq2_img,
                        input int br_k, input int br_new,
                        input int blk_on, input int blk_off);
        int       errs [8];
        int       cnt  [8];
        int       slot, p;
        logic     lit;
        logic [7:0] ed, es;
        for (int s = 0; s < 8; s++) begin
            errs[s] = 0;
            cnt[s]  = 0;
        end
        for (int k = 0; k < 512; k++) begin
            step();
            slot = k / 64;
            p    = (k % 64) / 4;
            lit  = (p >= DEAD) && (p < DEAD + br) && !blank;
            ed   = lit ? (8'h01 << slot) : 8'h00;
            es   = lit ? img[8*slot +: 8] : 8'h00;
            if (dig !== ed || seg !== es || didx !== slot[2:0]) errs[slot]++;
            if (dig_n !== ~ed || seg_n !== 8'hFF || didx_n !== slot[2:0]) errs[slot]++;
            if (k < 511 && (fs !== 1'b0 || fs_n !== 1'b0)) errs[slot]++;
            if (dig !== 8'h00) cnt[slot]++;
            if (k == blk_on)  blank = 1'b1;
            if (k == blk_off) blank = 1'b0;
            if (k == br_k)    brightness = br_new[3:0];
            if (k == rq1_k)   drive_req(rq1_img);
            if (k == rq2_k)   drive_req(rq2_img);
        end
        chk("fs_period", fs, 1);
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("slot%0d_errs", s), errs[s], 0);
            if (exp_cnt >= 0) chk($sformatf("slot%0d_lit", s), cnt[s], exp_cnt);
        end
        fs_cyc = cyc;
    endtask

    logic [63:0] img_a, img_b, img_c, img_d, img_e;
    int fs4, d_req, acks_before;

    initial begin
        img_a = 64'h0706050403020100;
        img_b = 64'h8877665544332211;
        img_c = 64'hC7C6C5C4C3C2C1C0;
        img_d = 64'hDEADBEEF01234567;
        img_e = 64'h0F0E0D0C0B0A0908;
        brightness    = 4'd15;
        blank         = 1'b0;
        ifc.upd_req   = 1'b0;
        ifc.upd_img   = 64'd0;
        ifc_n.upd_req = 1'b0;
        ifc_n.upd_img = 64'd0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 8'h00);
        chk("rst_dig", dig, 8'h00);
        chk("rst_idx", didx, 3'd0);
        chk("rst_fs", fs, 1'b0);
        chk("rst_ack", ifc.upd_ack, 1'b0);
        chk("rst_seg_inv", seg_n, 8'hFF);
        chk("rst_dig_inv", dig_n, 8'hFF);
        rst = 1'b0;

        wait_fs();
        scan(64'd0, 15, 56, 100, img_a, -1, 64'd0, -1, 0, -1, -1);
        chk("ack_a_latency", ack_cyc, req_cyc + 1);
        chk("ack_count_1", ack_count, 1);

        scan(img_a, 15, 56, -1, 64'd0, -1, 64'd0, 460, 3, -1, -1);
        scan(img_a, 3, 12, -1, 64'd0, -1, 64'd0, 460, 0, -1, -1);
        scan(img_a, 0, 0, 100, img_b, 200, img_c, 460, 15, -1, -1);
        chk("ack_count_2", ack_count, 2);
        chk("req_c_held", ifc.upd_req, 1'b1);
        fs4 = fs_cyc;

        scan(img_b, 15, 56, -1, 64'd0, -1, 64'd0, -1, 0, -1, -1);
        chk("ack_c_after_swap", ack_cyc, fs4 + 1);
        chk("ack_count_3", ack_count, 3);
        scan(img_c, 15, 56, -1, 64'd0, -1, 64'd0, -1, 0, -1, -1);
        scan(img_c, 15, -1, -1, 64'd0, -1, 64'd0, -1, 0, 100, 200);

        d_req = 0;
        for (int k = 0; k <= 150; k++) begin
            step();
            if (k == 50) begin
                drive_req(img_d);
                d_req = req_cyc;
            end
            if (k == 100) drive_req(img_e);
        end
        chk("ack_d_latency", ack_cyc, d_req + 1);
        chk("pre_rst_dig", dig, 8'h04);
        chk("pre_rst_seg", seg, 8'hC2);
        chk("pre_rst_dig_inv", dig_n, 8'hFB);
        #2 rst = 1'b1;
        #1;
        chk("async_seg", seg, 8'h00);
        chk("async_dig", dig, 8'h00);
        chk("async_idx", didx, 3'd0);
        chk("async_seg_inv", seg_n, 8'hFF);
        chk("async_dig_inv", dig_n, 8'hFF);
        ifc.upd_req = 1'b0;
        acks_before = ack_count;
        repeat (2) @(negedge clk);
        chk("rst_no_ack", ifc.upd_ack, 1'b0);
        rst = 1'b0;
        wait_fs();
        chk("no_ack_after_rst", ack_count, acks_before);
        scan(64'd0, 15, 56, -1, 64'd0, -1, 64'd0, -1, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
